alu_operand_seq: RTL and testbench
==================================

Name: alu_operand_seq

Overview:
- Upstream operand-entry stage for the 8-bit ALU datapath.
- One 8-bit switch bank and a "next" push-button enter A, then B, then the 3-bit opcode. The block then holds all three stable for the ALU and display path.
- Replaces direct wiring of sw/sw_b/sel, so the board needs only 8 switches plus 2 buttons.
- Contains button synchronisation, debounce, edge detection and a 4-phase entry FSM.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synced cycles required to accept a button level change (10 ms at 100 MHz); must be ≥2.
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- sw  in  8  operand/opcode switch bank
- btn_next  in  1  raw asynchronous "next" button, active-high
- btn_clr  in  1  raw asynchronous "clear" button, active-high
- a_out  out  8  latched operand A
- b_out  out  8  latched operand B
- op_out  out  3  latched ALU opcode
- phase  out  2  current FSM phase (encoding below)
- result_valid  out  1  high only in phase RUN
- next_pulse  out  1  one-cycle debounced rising edge of btn_next (debug/LED)

Behaviour:
- Reset: sampled only on the rising edge of clk while rst_n=0. On reset:
  - a_out=0, b_out=0, op_out=0
  - phase=LOAD_A, result_valid=0, next_pulse=0
  - synchronisers, debounce counters and stable levels=0
- Synchronisers: each button passes through a 2-flop synchroniser before debounce.
- Debounce, per button:
  - Counter resets to 0 whenever synced level == stable level.
  - Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable level toggles and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Edge detect: next_pulse/clr_pulse is high for exactly one cycle, the cycle after the stable level goes 0→1. Releases generate no pulse.
- Latency: raw btn_next held high → next_pulse high DEBOUNCE_CYCLES+2 cycles after the first clock edge that samples it high. Registers/phase update on the clock edge where the pulse is high.
- Phase encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, RUN=3.
- Transitions on next_pulse:
  - LOAD_A: a_out←sw, go to LOAD_B.
  - LOAD_B: b_out←sw, go to LOAD_OP.
  - LOAD_OP: op_out←sw[2:0], go to RUN.
  - RUN: go to LOAD_A, a/b/op retained.
- sw is sampled directly (static switches, no synchroniser). The value latched is sw at the update edge.
- clr_pulse: a_out, b_out, op_out←0 and phase←LOAD_A from any phase.
- clr_pulse has priority over next_pulse in the same cycle.
- result_valid = (phase==RUN), registered together with phase (no extra lag).
- Outputs change only on a next/clr event or reset. Holding a button produces exactly one event.
- Reset mid-debounce discards the pending count. The button must be re-held for a full DEBOUNCE_CYCLES after reset is released.

Decomposition:
- Shared package alu_seq_pkg holds:
  - the PHASE_LOAD_A/B/OP/RUN localparams (2-bit)
  - DEBOUNCE_CYCLES default
- One sub-module btn_debounce, instantiated twice:
  - contains synchroniser, counter, stable level and rising-edge pulse
  - parameters DEBOUNCE_CYCLES, CNT_W
  - ports clk, rst_n, btn_raw, level, rise_pulse
- Top of this block holds the FSM and operand registers only.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: rst_n=0 for 3 cycles, with btn_next held high throughout → all outputs 0, phase=0. After release, the first next_pulse arrives no earlier than 6 cycles later.
- Full entry: sw=0x3C + press, sw=0x05 + press, sw=0x02 + press → a_out=0x3C, b_out=0x05, op_out=2, phase=3, result_valid=1. A fourth press → phase=0, values retained.
- Bounce rejection: btn_next toggles high 2 cycles / low 1 cycle ×5, then low → no next_pulse, phase unchanged. A clean 10-cycle hold → exactly one pulse.
- Clear priority: in LOAD_OP with A=0xAA and B=0x55, press btn_next and btn_clr in the same cycle → phase=0, a/b/op=0, result_valid=0.
- Long hold: btn_next held for 50 cycles in LOAD_A → exactly one advance, to LOAD_B. Release and press again → LOAD_OP.
- Switch change after latch: latch A=0x81, then set sw=0xFF without pressing → a_out stays 0x81.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand-entry stage: phase encoding and
// the default debounce length.
package alu_seq_pkg;

    localparam logic [1:0] PHASE_LOAD_A  = 2'd0;
    localparam logic [1:0] PHASE_LOAD_B  = 2'd1;
    localparam logic [1:0] PHASE_LOAD_OP = 2'd2;
    localparam logic [1:0] PHASE_RUN     = 2'd3;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int CNT_W_DEF           = 20;

    typedef enum logic [1:0] {
        ST_LOAD_A  = PHASE_LOAD_A,
        ST_LOAD_B  = PHASE_LOAD_B,
        ST_LOAD_OP = PHASE_LOAD_OP,
        ST_RUN     = PHASE_RUN
    } phase_e;

    // Phase that follows st on a "next" event.
    function automatic phase_e phase_after(input phase_e st);
        phase_e nxt;
        case (st)
            ST_LOAD_A:  nxt = ST_LOAD_B;
            ST_LOAD_B:  nxt = ST_LOAD_OP;
            ST_LOAD_OP: nxt = ST_RUN;
            ST_RUN:     nxt = ST_LOAD_A;
            default:    nxt = ST_LOAD_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each debounced press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter runs only while the synced input disagrees with the accepted level.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        rise_d = stable_q & ~stable_prev_q;
    end

    // Synchroniser, debounce state and edge-detect registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            rise_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            rise_q        <= rise_d;
            cnt_q         <= cnt_d;
        end
    end

    assign level      = stable_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/alu_operand_seq.sv
// Operand-entry stage: one switch bank and a "next" button load A, B and the
// opcode in turn, then hold them for the ALU; "clear" returns to LOAD_A.
module alu_operand_seq
    import alu_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       btn_next,
    input  logic       btn_clr,
    output logic [7:0] a_out,
    output logic [7:0] b_out,
    output logic [2:0] op_out,
    output logic [1:0] phase,
    output logic       result_valid,
    output logic       next_pulse
);

    logic next_pulse_s, clr_pulse_s;
    logic unused_next_level_s, unused_clr_level_s;

    phase_e     phase_q, phase_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] op_q, op_d;
    logic       rv_q, rv_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_next_db (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_next),
        .level      (unused_next_level_s),
        .rise_pulse (next_pulse_s)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_clr_db (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_clr),
        .level      (unused_clr_level_s),
        .rise_pulse (clr_pulse_s)
    );

    // Entry FSM; clear wins over next when both pulse in the same cycle.
    always_comb begin
        phase_d = phase_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (clr_pulse_s) begin
            phase_d = ST_LOAD_A;
            a_d     = 8'h00;
            b_d     = 8'h00;
            op_d    = 3'd0;
        end else if (next_pulse_s) begin
            case (phase_q)
                ST_LOAD_A:  a_d  = sw;
                ST_LOAD_B:  b_d  = sw;
                ST_LOAD_OP: op_d = sw[2:0];
                ST_RUN:     op_d = op_q;
                default:    op_d = op_q;
            endcase
            phase_d = phase_after(phase_q);
        end else begin
            phase_d = phase_q;
        end
        rv_d = (phase_d == ST_RUN);
    end

    // Phase, operand and valid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= ST_LOAD_A;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            op_q    <= 3'd0;
            rv_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rv_q    <= rv_d;
        end
    end

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign op_out       = op_q;
    assign phase        = phase_q;
    assign result_valid = rv_q;
    assign next_pulse   = next_pulse_s;

endmodule

// File: tb/tb_alu_operand_seq.sv
// Scoreboard bench for alu_operand_seq with a short debounce length.
module tb_alu_operand_seq;

    localparam int DC = 4;
    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] sw;
    logic       btn_next, btn_clr;
    logic [7:0] a_out, b_out;
    logic [2:0] op_out;
    logic [1:0] phase;
    logic       result_valid, next_pulse;

    int tests  = 0;
    int failed = 0;
    int pulse_cnt = 0;

    // expected {a, b, op, phase, result_valid} after each next event
    logic [21:0] exp_q[$];

    int         m_ph = 0;
    logic [7:0] m_a = 8'h00, m_b = 8'h00;
    logic [2:0] m_op = 3'd0;

    alu_operand_seq #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw           (sw),
        .btn_next     (btn_next),
        .btn_clr      (btn_clr),
        .a_out        (a_out),
        .b_out        (b_out),
        .op_out       (op_out),
        .phase        (phase),
        .result_valid (result_valid),
        .next_pulse   (next_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] m_vec();
        logic [1:0] p;
        p = 2'(m_ph);
        return {m_a, m_b, m_op, p, (m_ph == 3)};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {a_out, b_out, op_out, phase, result_valid};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the switch value goes to the slot named by the phase, then the phase advances.
    task automatic m_next(input logic [7:0] v);
        if (m_ph == 0) m_a = v;
        else if (m_ph == 1) m_b = v;
        else if (m_ph == 2) m_op = v[2:0];
        m_ph = (m_ph + 1) % 4;
        exp_q.push_back(m_vec());
    endtask

    task automatic m_clr();
        m_a = 8'h00; m_b = 8'h00; m_op = 3'd0; m_ph = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] v, input logic nxt, input logic clr, input int hold);
        sw = v;
        btn_next = nxt;
        btn_clr  = clr;
        repeat (hold) tick();
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        repeat (12) tick();
    endtask

    // Monitor: on every next_pulse, compare the state one cycle later with the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && next_pulse === 1'b1) begin
            pulse_cnt++;
            @(negedge clk);
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_pulse: got state 0x%0h with no expected event", dut_vec());
            end else begin
                check("scoreboard", 32'(dut_vec()), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int k;
        int c0;
        logic [7:0] v;

        rst_n = 1'b0; btn_next = 1'b1; btn_clr = 1'b0; sw = 8'h11;
        repeat (3) tick();
        check("reset_state", 32'(dut_vec()), 32'h0);
        check("reset_pulse", 32'(next_pulse), 32'h0);

        // Button held through reset: the count only starts after release.
        m_next(8'h11);
        rst_n = 1'b1;
        k = 0;
        while (k < 20 && next_pulse !== 1'b1) begin
            tick();
            k++;
        end
        check("rst_latency_min6", 32'(k >= 6), 32'h1);
        check("rst_latency_bound", 32'(k < 20), 32'h1);
        btn_next = 1'b0;
        repeat (12) tick();

        m_clr();
        press(8'h99, 1'b0, 1'b1, 10);
        check("clear_only", 32'(dut_vec()), 32'(m_vec()));

        m_next(8'h3C); press(8'h3C, 1'b1, 1'b0, 10);
        m_next(8'h05); press(8'h05, 1'b1, 1'b0, 10);
        m_next(8'h02); press(8'h02, 1'b1, 1'b0, 10);
        check("full_entry", 32'(dut_vec()), {10'd0, 8'h3C, 8'h05, 3'd2, 2'd3, 1'b1});
        m_next(8'h77); press(8'h77, 1'b1, 1'b0, 10);
        check("fourth_press", 32'(dut_vec()), {10'd0, 8'h3C, 8'h05, 3'd2, 2'd0, 1'b0});

        c0 = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1; tick(); tick();
            btn_next = 1'b0; tick();
        end
        repeat (12) tick();
        check("bounce_no_pulse", 32'(pulse_cnt), 32'(c0));
        check("bounce_phase", 32'(phase), 32'(m_ph));

        m_next(8'h81); press(8'h81, 1'b1, 1'b0, 10);
        check("clean_hold_one_pulse", 32'(pulse_cnt), 32'(c0 + 1));
        sw = 8'hFF;
        repeat (10) tick();
        check("sw_change_a_held", 32'(a_out), 32'h81);

        m_clr(); press(8'h00, 1'b0, 1'b1, 10);
        m_next(8'hAA); press(8'hAA, 1'b1, 1'b0, 10);
        m_next(8'h55); press(8'h55, 1'b1, 1'b0, 10);
        check("in_load_op", 32'(phase), 32'h2);
        m_clr();
        exp_q.push_back(m_vec());
        press(8'h07, 1'b1, 1'b1, 10);
        check("clear_priority", 32'(dut_vec()), 32'h0);

        c0 = pulse_cnt;
        m_next(8'h5A); press(8'h5A, 1'b1, 1'b0, 50);
        check("long_hold_one_pulse", 32'(pulse_cnt), 32'(c0 + 1));
        check("long_hold_phase", 32'(phase), 32'h1);
        m_next(8'h33); press(8'h33, 1'b1, 1'b0, 10);
        check("second_press_phase", 32'(phase), 32'h2);

        for (int i = 0; i < 24; i++) begin
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) begin
                m_clr();
                press(v, 1'b0, 1'b1, 10);
                check("rand_clear", 32'(dut_vec()), 32'(m_vec()));
            end else begin
                m_next(v);
                press(v, 1'b1, 1'b0, $urandom_range(8, 20));
            end
        end

        repeat (5) tick();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        check("final_state", 32'(dut_vec()), 32'(m_vec()));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
